// File: rtl/seq_nr_divider_if.sv
// Operand/result handshake bundle for seq_nr_divider.
// The master drives operands and takes results; the slave is the divider.
interface seq_nr_divider_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_nr_divider.sv
// Iterative non-restoring divider: one WIDTH+1-bit add/sub step per cycle.
// Define DIV_SIGNED_EN for two's-complement operands (adds a SIGN correction cycle).
module seq_nr_divider #(
    parameter int unsigned WIDTH = 8
) (
    input logic            clk,
    input logic            rst_n,
    seq_nr_divider_if.slave bus
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {StIdle, StCalc, StFix, StSign, StDone} state_t;

    state_t           state_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [CntW-1:0]  cnt_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             dbz_q;
`ifdef DIV_SIGNED_EN
    logic             neg_quot_q;
    logic             neg_rem_q;
`endif

    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH:0]   r_shift;
    logic [WIDTH:0]   add_a;
    logic [WIDTH:0]   add_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   r_fixed;
    logic             addsuben;

    // Magnitudes go into the iterative core; signs are re-applied afterwards.
    always_comb begin
`ifdef DIV_SIGNED_EN
        dvd_mag = bus.dividend[WIDTH-1] ? -bus.dividend : bus.dividend;
        dvs_mag = bus.divisor[WIDTH-1]  ? -bus.divisor  : bus.divisor;
`else
        dvd_mag = bus.dividend;
        dvs_mag = bus.divisor;
`endif
    end

    // Shared adder: subtract while R>=0 in CALC, otherwise add D (also the FIX restore).
    always_comb begin
        r_shift = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
        if (state_q == StCalc) begin
            add_a    = r_shift;
            addsuben = ~r_q[WIDTH];
        end else begin
            add_a    = r_q;
            addsuben = 1'b0;
        end
        add_b   = addsuben ? ~{1'b0, d_q} : {1'b0, d_q};
        sum     = add_a + add_b + {{WIDTH{1'b0}}, addsuben};
        r_fixed = r_q[WIDTH] ? sum : r_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            r_q         <= '0;
            q_q         <= '0;
            d_q         <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quot_q  <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        r_q        <= '0;
                        q_q        <= dvd_mag;
                        d_q        <= dvs_mag;
                        cnt_q      <= '0;
                        dbz_q      <= 1'b0;
`ifdef DIV_SIGNED_EN
                        neg_quot_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                        neg_rem_q  <= bus.dividend[WIDTH-1];
`endif
                        if (bus.divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend;
                            dbz_q       <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    r_q   <= sum;
                    q_q   <= {q_q[WIDTH-2:0], ~sum[WIDTH]};
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    r_q         <= r_fixed;
                    quotient_q  <= q_q;
                    remainder_q <= r_fixed[WIDTH-1:0];
`ifdef DIV_SIGNED_EN
                    state_q     <= StSign;
`else
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
`endif
                end
                StSign: begin
`ifdef DIV_SIGNED_EN
                    if (neg_quot_q) quotient_q  <= -quotient_q;
                    if (neg_rem_q)  remainder_q <= -remainder_q;
`endif
                    out_valid_q <= 1'b1;
                    state_q     <= StDone;
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;

endmodule
